// File: rtl/lzrw1_decompressor_stream.sv
// LZRW1 streaming decompressor: literal/copy items in, bytes out,
// with an on-chip sliding history window and ready/valid on both sides.
module lzrw1_decompressor_stream #(
  parameter int OFFSET_W  = 12,
  parameter int LEN_W     = 4,
  parameter int MIN_MATCH = 3,
  parameter int CNT_W     = 32,
  localparam int DATA_W   = LEN_W + OFFSET_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_control,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [7:0]        out_byte,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              error,
  output logic [CNT_W-1:0]  bytes_out
);

  localparam int DEPTH = 1 << OFFSET_W;
  localparam int REM_W = $clog2((1 << LEN_W) + MIN_MATCH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LIT  = 2'd1;
  localparam logic [1:0] S_COPY = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [OFFSET_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [OFFSET_W-1:0] src_q, src_d;
  logic [OFFSET_W-1:0] fill_q, fill_d;
  logic [REM_W-1:0]    rem_q, rem_d;
  logic [7:0]          obyte_q, obyte_d;
  logic                ovalid_q, ovalid_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [7:0]          hist [DEPTH];
  logic                we;
  logic [OFFSET_W-1:0] rd_addr;
  logic [7:0]          rd_data;

  logic                in_fire;
  logic                out_fire;
  logic [LEN_W-1:0]    code;
  logic [OFFSET_W-1:0] offset;
  logic                legal;
  logic [OFFSET_W-1:0] src_nx;

  assign in_ready  = reset && (state_q == S_IDLE) && !ovalid_q;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = ovalid_q && out_ready;
  assign code      = in_data[DATA_W-1:OFFSET_W];
  assign offset    = in_data[OFFSET_W-1:0];
  assign legal     = (offset != '0) && (offset <= fill_q);
  assign src_nx    = src_q + OFFSET_W'(1);
  assign rd_data   = hist[rd_addr];

  assign out_byte  = obyte_q;
  assign out_valid = ovalid_q;
  assign busy      = (state_q != S_IDLE);
  assign error     = err_q;
  assign bytes_out = cnt_q;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    src_d    = src_q;
    fill_d   = fill_q;
    rem_d    = rem_q;
    obyte_d  = obyte_q;
    ovalid_d = ovalid_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    we       = 1'b0;
    rd_addr  = src_q;

    // every emitted byte is committed to history as it leaves
    if (out_fire) begin
      we       = 1'b1;
      wr_ptr_d = wr_ptr_q + OFFSET_W'(1);
      fill_d   = (&fill_q) ? fill_q : fill_q + OFFSET_W'(1);
      cnt_d    = cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (in_fire) begin
          if (!in_control) begin
            obyte_d  = in_data[7:0];
            ovalid_d = 1'b1;
            state_d  = S_LIT;
          end else if (!legal) begin
            err_d = 1'b1;
          end else begin
            src_d   = wr_ptr_q - offset;
            rem_d   = REM_W'(code) + REM_W'(MIN_MATCH);
            state_d = S_COPY;
          end
        end
      end
      S_LIT: begin
        if (out_fire) begin
          ovalid_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      S_COPY: begin
        if (!ovalid_q) begin
          obyte_d  = rd_data;
          ovalid_d = 1'b1;
        end else if (out_fire) begin
          src_d = src_nx;
          rem_d = rem_q - REM_W'(1);
          if (rem_q == REM_W'(1)) begin
            ovalid_d = 1'b0;
            state_d  = S_IDLE;
          end else begin
            rd_addr = src_nx;
            // overlapping copy: next source is the slot written now
            obyte_d = (src_nx == wr_ptr_q) ? obyte_q : rd_data;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (clear) begin
      state_d  = S_IDLE;
      wr_ptr_d = '0;
      src_d    = '0;
      fill_d   = '0;
      rem_d    = '0;
      obyte_d  = '0;
      ovalid_d = 1'b0;
      err_d    = 1'b0;
      cnt_d    = '0;
      we       = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      src_q    <= '0;
      fill_q   <= '0;
      rem_q    <= '0;
      obyte_q  <= '0;
      ovalid_q <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      src_q    <= src_d;
      fill_q   <= fill_d;
      rem_q    <= rem_d;
      obyte_q  <= obyte_d;
      ovalid_q <= ovalid_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (we) hist[wr_ptr_q] <= obyte_q;
  end

endmodule

// File: tb/tb_lzrw1_decompressor_stream.sv
// Bench for lzrw1_decompressor_stream: item table plus
// backpressure, reset, error and window-wrap sequences.
module tb_lzrw1_decompressor_stream;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_control = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        busy;
  logic        error;
  logic [31:0] bytes_out;

  int errors = 0;
  int checks = 0;

  logic [7:0] sb[$];
  logic [7:0] mh[$];

  typedef struct {
    bit          clr;
    bit          ctrl;
    logic [15:0] data;
    int          lat;
    int          rep;
    logic [7:0]  b0;
    logic [7:0]  b1;
  } item_t;

  item_t tbl[12];
  bit    pat[4];

  lzrw1_decompressor_stream dut (
    .clock      (clock),
    .reset      (reset),
    .clear      (clear),
    .in_data    (in_data),
    .in_control (in_control),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_byte   (out_byte),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .error      (error),
    .bytes_out  (bytes_out)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic expect_byte(input logic [7:0] b);
    sb.push_back(b);
    mh.push_back(b);
  endtask

  task automatic send(input bit c, input logic [15:0] d);
    int n;
    n = 0;
    in_control = c;
    in_data    = d;
    in_valid   = 1'b1;
    @(negedge clock);
    while (!in_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy || out_valid) && n < 300) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("drain", sb.size(), 32'd0);
  endtask

  task automatic do_clear();
    @(posedge clock);
    #1;
    clear = 1'b1;
    sb.delete();
    mh.delete();
    @(posedge clock);
    #1;
    clear = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 16'h0041, 1, 1,  8'h41, 8'h41};
    tbl[1]  = '{1'b0, 1'b0, 16'h0042, 1, 1,  8'h42, 8'h42};
    tbl[2]  = '{1'b0, 1'b0, 16'h0043, 1, 1,  8'h43, 8'h43};
    tbl[3]  = '{1'b1, 1'b0, 16'h0061, 1, 1,  8'h61, 8'h61};
    tbl[4]  = '{1'b0, 1'b0, 16'h0062, 1, 1,  8'h62, 8'h62};
    tbl[5]  = '{1'b0, 1'b1, 16'h1002, 2, 4,  8'h61, 8'h62};
    tbl[6]  = '{1'b1, 1'b0, 16'h0078, 1, 1,  8'h78, 8'h78};
    tbl[7]  = '{1'b0, 1'b1, 16'hF001, 2, 18, 8'h78, 8'h78};
    tbl[8]  = '{1'b1, 1'b0, 16'h0061, 1, 1,  8'h61, 8'h61};
    tbl[9]  = '{1'b0, 1'b0, 16'h0062, 1, 1,  8'h62, 8'h62};
    tbl[10] = '{1'b0, 1'b1, 16'h0005, 0, 0,  8'h00, 8'h00};
    tbl[11] = '{1'b0, 1'b0, 16'hC37A, 1, 1,  8'h7A, 8'h7A};
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};

    fork
      forever begin
        @(negedge clock);
        if (reset && out_valid && out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_byte: got %0h expected none", out_byte);
          end else begin
            chk("out_byte", {24'd0, out_byte}, {24'd0, sb.pop_front()});
          end
        end
      end
    join_none

    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    chk("rst_in_ready_rel", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_byte", {24'd0, out_byte}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_bytes_out", bytes_out, 32'd0);

    for (int i = 0; i < 12; i++) begin
      int c;
      int r;
      if (tbl[i].clr) begin
        drain();
        do_clear();
      end
      for (int k = 0; k < tbl[i].rep; k++)
        expect_byte((k % 2) != 0 ? tbl[i].b1 : tbl[i].b0);
      send(tbl[i].ctrl, tbl[i].data);
      if (tbl[i].lat == 0) begin
        chk("illegal_in_ready", {31'd0, in_ready}, 32'd1);
        chk("illegal_error", {31'd0, error}, 32'd1);
        repeat (3) begin
          chk("illegal_no_out", {31'd0, out_valid}, 32'd0);
          @(posedge clock);
          #1;
        end
      end else begin
        c = 1;
        while (!out_valid && c < 10) begin
          @(posedge clock);
          #1;
          c++;
        end
        chk("latency", c, tbl[i].lat);
        r = 0;
        while (out_valid && r < 100) begin
          r++;
          @(posedge clock);
          #1;
        end
        chk("run_length", r, tbl[i].rep);
        chk("bytes_out_item", bytes_out, mh.size());
      end
    end

    drain();
    chk("error_sticky", {31'd0, error}, 32'd1);
    do_clear();
    chk("clear_error", {31'd0, error}, 32'd0);
    chk("clear_bytes_out", bytes_out, 32'd0);

    // 18-byte overlapping copy under a 1,0,0,1 ready pattern
    for (int i = 0; i < 3; i++) begin
      expect_byte(8'(8'h61 + i));
      send(1'b0, 16'(8'h61 + i));
    end
    drain();
    for (int k = 0; k < 18; k++) expect_byte(mh[mh.size() - 3]);
    send(1'b1, 16'hF003);
    for (int i = 0; i < 400 && (sb.size() != 0 || busy); i++) begin
      logic [7:0] hb;
      bit hold;
      out_ready = pat[i % 4];
      hold = !out_ready && out_valid;
      hb = out_byte;
      @(posedge clock);
      #1;
      if (hold) begin
        chk("bp_hold_byte", {24'd0, out_byte}, {24'd0, hb});
        chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      end
    end
    out_ready = 1'b1;
    drain();
    chk("bp_bytes_out", bytes_out, mh.size());

    // reset in the middle of a copy
    for (int k = 0; k < 18; k++) expect_byte(mh[mh.size() - 3]);
    send(1'b1, 16'hF003);
    repeat (5) @(posedge clock);
    #1;
    reset = 1'b0;
    sb.delete();
    mh.delete();
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_bytes_out", bytes_out, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    chk("midrst_in_ready_rel", {31'd0, in_ready}, 32'd1);
    chk("midrst_out_valid_rel", {31'd0, out_valid}, 32'd0);

    // fill beyond the window, then copy from the far end
    for (int i = 0; i < 4100; i++) begin
      logic [7:0] b;
      b = 8'(i * 7 + 3);
      expect_byte(b);
      send(1'b0, {8'hA5, b});
    end
    drain();
    for (int k = 0; k < 18; k++) expect_byte(mh[mh.size() - 4095]);
    send(1'b1, 16'hFFFF);
    drain();
    chk("wrap_bytes_out", bytes_out, mh.size());
    chk("wrap_error", {31'd0, error}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
